// File: rtl/ct_rd_arbiter_if.sv
// Shared read-port bundle between the ciphertext-memory read arbiter and its
// requesters plus the memory read data path.
`timescale 1ns/1ps
interface ct_rd_arbiter_if #(
  parameter int N      = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  // Handshake: a requester holds req[i] and its addr slice stable until gnt[i]
  // is seen in the same cycle; the returned word is qualified by a one-cycle
  // rvalid[i] pulse RD_LAT+1 cycles after that grant, with rdata shared.
  logic [N-1:0]        req;
  logic [N*ADDR_W-1:0] addr;
  logic [N-1:0]        gnt;
  logic [N-1:0]        rvalid;
  logic [DATA_W-1:0]   rdata;
  logic                busy;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_rddata;

  modport slave (
    input  req, addr, mem_rddata,
    output gnt, rvalid, rdata, busy, mem_addr
  );

  modport master (
    output req, addr, mem_rddata,
    input  gnt, rvalid, rdata, busy, mem_addr
  );
endinterface

// File: rtl/ct_rd_arbiter.sv
// Round-robin arbiter sharing the ct_mem read port between N cracking cores,
// one grant per cycle, with in-flight tracking to route returned bytes.
`timescale 1ns/1ps
module ct_rd_arbiter #(
  parameter int N      = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ct_rd_arbiter_if.slave       bus,
  output logic [$clog2(N)-1:0] dbg_ptr_o
);
  localparam int PTR_W = $clog2(N);

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W-1:0] last_addr_q;
  logic [ADDR_W-1:0] addr_sel;
  logic [N-1:0]      gnt;
  logic              gnt_any;
  logic [PTR_W-1:0]  gnt_id;

  // vld_q is one stage deeper than id_q: the last stage only feeds busy,
  // its id already lives in rvalid_q.
  logic [RD_LAT:0]   vld_q;
  logic [PTR_W-1:0]  id_q [RD_LAT];
  logic [N-1:0]      rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_id  = ptr_q;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(N)) sum = sum - (PTR_W+1)'(N);
      idx = sum[PTR_W-1:0];
      if (!gnt_any && bus.req[idx]) begin
        gnt_any  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

  // With no grant the memory keeps seeing the last issued address.
  always_comb begin
    addr_sel = last_addr_q;
    for (int k = 0; k < N; k++) begin
      if (gnt[k]) addr_sel = bus.addr[k*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt_id == PTR_W'(N-1)) ? '0 : gnt_id + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      last_addr_q <= '0;
      vld_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      for (int k = 0; k < RD_LAT; k++) id_q[k] <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (gnt_any) last_addr_q <= addr_sel;
      vld_q <= {vld_q[RD_LAT-1:0], gnt_any};
      id_q[0] <= gnt_id;
      for (int k = 1; k < RD_LAT; k++) id_q[k] <= id_q[k-1];
      rvalid_q <= '0;
      // Entry at stage RD_LAT-1 is exactly when its memory data is valid.
      if (vld_q[RD_LAT-1]) begin
        rvalid_q[id_q[RD_LAT-1]] <= 1'b1;
        rdata_q                  <= bus.mem_rddata;
      end
    end
  end

  assign bus.gnt      = gnt;
  assign bus.mem_addr = addr_sel;
  assign bus.rvalid   = rvalid_q;
  assign bus.rdata    = rdata_q;
  assign bus.busy     = |vld_q;
  assign dbg_ptr_o    = ptr_q;
endmodule

// File: tb/tb_ct_rd_arbiter.sv
// Directed bench for ct_rd_arbiter: instance A (N=2, RD_LAT=1) and
// instance B (N=4, RD_LAT=3), each with its own ct_mem read model.
`timescale 1ns/1ps
module tb_ct_rd_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ct_rd_arbiter_if #(.N(2), .ADDR_W(8), .DATA_W(8)) a_if();
  ct_rd_arbiter_if #(.N(4), .ADDR_W(8), .DATA_W(8)) b_if();
  logic [0:0] a_ptr;
  logic [1:0] b_ptr;

  ct_rd_arbiter #(.N(2), .ADDR_W(8), .DATA_W(8), .RD_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave), .dbg_ptr_o(a_ptr));
  ct_rd_arbiter #(.N(4), .ADDR_W(8), .DATA_W(8), .RD_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave), .dbg_ptr_o(b_ptr));

  // ct_mem read models: mem[k] = k ^ 8'hA5, RD_LAT registers deep
  logic [7:0] mem [256];
  logic [7:0] a_rd, b_p0, b_p1, b_p2;
  initial for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
  always_ff @(posedge clk) begin
    a_rd <= mem[a_if.mem_addr];
    b_p0 <= mem[b_if.mem_addr];
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end
  assign a_if.mem_rddata = a_rd;
  assign b_if.mem_rddata = b_p2;

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] emem(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 2ns after the active edge, outputs sampled 2ns later.
  task automatic next_drive();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    next_drive();
    rst_n = 1'b0;
    a_if.req = '0; a_if.addr = '0;
    b_if.req = '0; b_if.addr = '0;
    next_drive();
    next_drive();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       rst_before;
    logic [1:0] req;
    logic [7:0] a0, a1;
    logic [1:0] gnt, rvalid;
    logic [7:0] rdata, mem_addr;
    logic       busy;
  } vec_t;
  vec_t vecs[$];

  initial begin
    vec_t v;
    int g, gl;
    a_if.req = '0; a_if.addr = '0;
    b_if.req = '0; b_if.addr = '0;

    // Single requester: req0 held, addresses 0..7, then drain
    for (int k = 0; k <= 10; k++) begin
      v.rst_before = (k == 0);
      v.req      = (k < 8) ? 2'b01 : 2'b00;
      v.a0       = (k < 8) ? 8'(k) : 8'h00;
      v.a1       = 8'h00;
      v.gnt      = (k < 8) ? 2'b01 : 2'b00;
      v.mem_addr = (k < 8) ? 8'(k) : 8'h07;
      v.rvalid   = (k >= 2 && k <= 9) ? 2'b01 : 2'b00;
      gl         = (k - 2 > 7) ? 7 : k - 2;
      v.rdata    = (k >= 2) ? emem(8'(gl)) : 8'h00;
      v.busy     = (k >= 1 && k <= 9);
      vecs.push_back(v);
    end
    // Contention: both requesting, req0 from 8'h10, req1 from 8'h20
    for (int c = 0; c <= 10; c++) begin
      v.rst_before = (c == 0);
      v.req      = (c < 8) ? 2'b11 : 2'b00;
      v.a0       = (c < 8) ? 8'h10 + 8'((c + 1) / 2) : 8'h00;
      v.a1       = (c < 8) ? 8'h20 + 8'(c / 2) : 8'h00;
      v.gnt      = (c >= 8) ? 2'b00 : ((c % 2) != 0) ? 2'b10 : 2'b01;
      v.mem_addr = (c >= 8) ? 8'h23 : ((c % 2) != 0) ? 8'h20 + 8'(c / 2) : 8'h10 + 8'(c / 2);
      g          = c - 2;
      v.rvalid   = (g >= 0 && g <= 7) ? (((g % 2) != 0) ? 2'b10 : 2'b01) : 2'b00;
      gl         = (g > 7) ? 7 : g;
      v.rdata    = (g < 0) ? 8'h00 :
                   ((gl % 2) != 0) ? emem(8'h20 + 8'(gl / 2)) : emem(8'h10 + 8'(gl / 2));
      v.busy     = (c >= 1 && c <= 9);
      vecs.push_back(v);
    end

    // Reset with random requests: registered outputs must stay cleared
    for (int c = 0; c < 4; c++) begin
      next_drive();
      rst_n = 1'b0;
      a_if.req  = 2'($urandom_range(0, 3));
      a_if.addr = 16'($urandom_range(0, 65535));
      b_if.req  = 4'($urandom_range(0, 15));
      b_if.addr = 32'($urandom);
      #2;
      chk("rst_a_rvalid", a_if.rvalid, 0);
      chk("rst_a_busy", a_if.busy, 0);
      chk("rst_a_rdata", a_if.rdata, 0);
      chk("rst_b_rvalid", b_if.rvalid, 0);
      chk("rst_b_busy", b_if.busy, 0);
      chk("rst_b_rdata", b_if.rdata, 0);
    end
    next_drive();
    rst_n = 1'b1;
    a_if.req = '0; b_if.req = '0;
    for (int c = 0; c < 20; c++) begin
      next_drive();
      #2;
      chk("idle_a_gnt", a_if.gnt, 0);
      chk("idle_a_rvalid", a_if.rvalid, 0);
      chk("idle_a_busy", a_if.busy, 0);
      chk("idle_a_memaddr", a_if.mem_addr, 0);
      chk("idle_b_rvalid", b_if.rvalid, 0);
      chk("idle_b_busy", b_if.busy, 0);
    end

    // Table-driven vectors on instance A
    foreach (vecs[i]) begin
      if (vecs[i].rst_before) do_reset();
      next_drive();
      a_if.req  = vecs[i].req;
      a_if.addr = {vecs[i].a1, vecs[i].a0};
      #2;
      chk($sformatf("vec%0d_gnt", i), a_if.gnt, vecs[i].gnt);
      chk($sformatf("vec%0d_memaddr", i), a_if.mem_addr, vecs[i].mem_addr);
      chk($sformatf("vec%0d_rvalid", i), a_if.rvalid, vecs[i].rvalid);
      chk($sformatf("vec%0d_rdata", i), a_if.rdata, vecs[i].rdata);
      chk($sformatf("vec%0d_busy", i), a_if.busy, vecs[i].busy);
    end

    // Pointer memory: grant req1 alone, idle 3 cycles, then both request
    do_reset();
    next_drive();
    a_if.req = 2'b10; a_if.addr = {8'h30, 8'h00};
    #2;
    chk("ptrmem_gnt1", a_if.gnt, 2'b10);
    next_drive();
    a_if.req = 2'b00;
    #2;
    chk("ptrmem_wrap", a_ptr, 0);
    chk("ptrmem_idle_gnt", a_if.gnt, 0);
    next_drive();
    #2;
    chk("ptrmem_rvalid", a_if.rvalid, 2'b10);
    chk("ptrmem_rdata", a_if.rdata, emem(8'h30));
    next_drive();
    #2;
    chk("ptrmem_rvalid_off", a_if.rvalid, 0);
    next_drive();
    a_if.req = 2'b11; a_if.addr = {8'h50, 8'h40};
    #2;
    chk("ptrmem_first", a_if.gnt, 2'b01);
    chk("ptrmem_first_addr", a_if.mem_addr, 8'h40);
    next_drive();
    a_if.addr = {8'h50, 8'h41};
    #2;
    chk("ptrmem_second", a_if.gnt, 2'b10);
    chk("ptrmem_second_addr", a_if.mem_addr, 8'h50);

    // Reset mid-flight: rst_n low one cycle after a grant to requester 1
    do_reset();
    next_drive();
    a_if.req = 2'b01; a_if.addr = {8'h00, 8'h60};
    #2;
    chk("midrst_gnt0", a_if.gnt, 2'b01);
    next_drive();
    a_if.req = 2'b10; a_if.addr = {8'h61, 8'h00};
    #2;
    chk("midrst_gnt1", a_if.gnt, 2'b10);
    next_drive();
    rst_n = 1'b0;
    a_if.req = 2'b00;
    #2;
    chk("midrst_busy", a_if.busy, 0);
    chk("midrst_rvalid", a_if.rvalid, 0);
    chk("midrst_rdata", a_if.rdata, 0);
    next_drive();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #2;
      chk("midrst_after_rvalid", a_if.rvalid, 0);
      chk("midrst_after_busy", a_if.busy, 0);
      next_drive();
    end

    // Latency sweep on instance B: all four requesting for 12 cycles
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      next_drive();
      b_if.req = (c < 12) ? 4'hF : 4'h0;
      for (int i = 0; i < 4; i++)
        b_if.addr[i*8 +: 8] = 8'h80 + 8'(i * 16) + ((c >= i) ? 8'((c - i + 3) / 4) : 8'h00);
      #2;
      g = c - 4;
      chk($sformatf("lat_c%0d_gnt", c), b_if.gnt, (c < 12) ? (4'b0001 << (c % 4)) : 4'b0000);
      chk($sformatf("lat_c%0d_ptr", c), b_ptr, (c < 12) ? 2'(c % 4) : 2'd0);
      chk($sformatf("lat_c%0d_rvalid", c), b_if.rvalid,
          (g >= 0 && g <= 11) ? (4'b0001 << (g % 4)) : 4'b0000);
      if (g >= 0 && g <= 11)
        chk($sformatf("lat_c%0d_rdata", c), b_if.rdata,
            emem(8'h80 + 8'((g % 4) * 16) + 8'(g / 4)));
      chk($sformatf("lat_c%0d_busy", c), b_if.busy, (c >= 1 && c <= 15));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ct_rd_arbiter.md
# ct_rd_arbiter

Round-robin read arbiter that shares the single read port of the ciphertext memory (`ct_mem`) between N cracking cores, e.g. the two crack cores inside `doublecrack`. Each core issues single-word read requests; the arbiter grants one per cycle, drives the shared memory address, and routes the returned byte to the requester that issued it. The arbiter is fully pipelined: with the memory's fixed read latency, it sustains one grant per cycle with no bubbles.

## Interface
Parameters:
- `N`, 2: number of requesters (2..8)
- `ADDR_W`, 8: ciphertext address width
- `DATA_W`, 8: ciphertext data width
- `RD_LAT`, 1: memory read latency in cycles, from address presented to `mem_rddata` valid (1..3)

Ports:
- `clk`  in  1  single clock for the block
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  N  per-requester read request; held with `addr` until granted
- `addr`  in  N*ADDR_W  requester i address in bits [i*ADDR_W +: ADDR_W]
- `gnt`  out  N  one-hot, combinational; high in the cycle requester i's address is issued
- `rvalid`  out  N  one-hot, registered; one-cycle pulse when requester i's data is on `rdata`
- `rdata`  out  DATA_W  registered returned data, shared by all requesters
- `busy`  out  1  high while any read is in flight
- `mem_addr`  out  ADDR_W  address to `ct_mem`, combinational mux of the granted address
- `mem_rddata`  in  DATA_W  read data from `ct_mem`

## Operation
- Priority pointer `ptr` (log2 N bits). Requester `ptr` has highest priority, then `ptr+1`, and so on, wrapping modulo N.
- Grant: the first asserted `req[i]` scanning from `ptr` gets `gnt[i]=1`, and `mem_addr = addr[i]`.
  - With no request, `gnt=0` and `mem_addr` holds its last issued value. It is 0 after reset.
- Pointer update at the clock edge ending a grant cycle: `ptr <= (i+1) mod N`. With no grant, `ptr` holds.
- In-flight tracking: a shift register RD_LAT+1 deep of {valid, requester id}. Stage 0 loads {|gnt, granted id} every cycle.
- Return path:
  - When the entry issued in cycle t reaches depth RD_LAT (cycle t+RD_LAT), `mem_rddata` is registered into `rdata`.
  - `rvalid[id]` is high in cycle t+RD_LAT+1 for exactly one cycle.
  - `rdata` holds its value between pulses.
- Requester protocol:
  - Keep `req[i]` and `addr[i]` stable until `gnt[i]` is seen.
  - `req[i]` may stay high after a grant to issue a new request; the next address must be presented in the following cycle.
  - Dropping `req` before a grant is legal; no grant and no rvalid result.
- `busy` = OR of all valid bits in the in-flight register.
- Writes are never issued. The top level ties `ct_mem` wren to 0.

## Timing
- Reset values (asynchronous on `rst_n` low):
  - `ptr=0`
  - all in-flight valid bits 0
  - `rvalid=0`, `rdata=0`, `busy=0`
  - registered last `mem_addr=0`
  - `gnt` is combinational and 0 whenever `req=0`.
- Reset mid-operation: all in-flight reads are discarded. No `rvalid` pulse appears after `rst_n` deasserts unless a new grant occurs.
- Latency: grant cycle t to `rvalid` cycle t+RD_LAT+1. For RD_LAT=1 that is 2 cycles.
- Throughput: one grant per cycle. Back-to-back grants to different requesters return in issue order, on consecutive cycles.
- Fairness: with all N requesting continuously, grants rotate 0,1,…,N-1,0,…. No requester waits more than N-1 cycles.
- Simultaneous events: a grant in the same cycle as an `rvalid` return is legal and independent. A requester may receive `gnt` and `rvalid` in the same cycle.
- Pointer wrap: after a grant to N-1, `ptr=0`.
- Every `gnt` pulse maps to exactly one later `rvalid` pulse to the same index. `rvalid` never has more than one bit set.

## Test plan
- Reset: drive `rst_n=0` with random `req`. Require `rvalid=0`, `busy=0`, `rdata=0`. Then release and hold `req=0`; outputs must stay idle for 20 cycles.
- Single requester: N=2, RD_LAT=1, mem preloaded with mem[k]=k^8'hA5. Hold req[0]=1 with addr 0..7 sequenced per grant. Require `gnt[0]` every cycle, `rvalid[0]` from cycle 2 on, and rdata = 8'hA5, 8'hA4, ….
- Contention: both requesters high from cycle 0, req0 on addr 8'h10, req1 on addr 8'h20. Require grant order 0,1,0,1. `rvalid` must alternate with matching data mem[8'h10+k] / mem[8'h20+k].
- Pointer memory: grant requester 1 alone, idle 3 cycles, then assert both requesters together. Requester 0 must win first.
- Latency sweep: RD_LAT=3 with N=4 and all four requesting. Require `rvalid` exactly 4 cycles after each `gnt`, and a rotation of 0,1,2,3.
- Reset mid-flight: assert `rst_n=0` one cycle after a grant to requester 1. No `rvalid[1]` pulse may appear, and `busy=0` immediately.
